// File: rtl/sha256_pkg.sv
// sha256_pkg: shared state encoding and padding helpers for the SHA-256 feeder and core
package sha256_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, OFFER} state_t;
    localparam logic [7:0] PAD_BYTE = 8'h80;
    function automatic logic [31:0] num_blocks(input logic [31:0] size);
        logic [32:0] s;
        s = {1'b0, size} + 33'd8;
        return {5'b0, s[32:6]} + 32'd1;
    endfunction
    function automatic logic [31:0] pad_word(input logic [31:0] data, input logic signed [39:0] r);
        return r >= 4 ? data :
               r == 3 ? {data[31:8], PAD_BYTE} :
               r == 2 ? {data[31:16], PAD_BYTE, 8'h00} :
               r == 1 ? {data[31:24], PAD_BYTE, 16'h0000} :
               r == 0 ? {PAD_BYTE, 24'h000000} : 32'h0;
    endfunction
endpackage

// File: rtl/sha256_block_padder.sv
// sha256_block_padder: reads a message from word memory and emits SHA-256 padded 512-bit blocks
module sha256_block_padder
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [31:0]  message_addr,
    input  logic [31:0]  size,
    output logic [15:0]  mem_addr,
    output logic         mem_we,
    input  logic [31:0]  mem_read_data,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_last,
    output logic         busy,
    output logic         done
);
    state_t state;
    logic [31:0] base, len, blk, last_blk;
    logic [4:0] c;
    logic [3:0] cw;
    logic [31:0] word;
    logic signed [39:0] r;
    logic final_blk;
    assign mem_we = 1'b0;
    always_comb begin
        cw = c[3:0] - 4'd1;
        final_blk = blk == last_blk;
        r = $signed({8'b0, len}) - $signed({2'b0, blk, cw, 2'b0});
        word = final_blk && cw == 4'd14 ? {29'b0, len[31:29]} :
               final_blk && cw == 4'd15 ? {len[28:0], 3'b0} : pad_word(mem_read_data, r);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mem_addr <= '0;
            blk_valid <= 1'b0;
            blk_last <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    base <= message_addr;
                    len <= size;
                    last_blk <= num_blocks(size) - 32'd1;
                    blk <= '0;
                    c <= '0;
                    busy <= 1'b1;
                    state <= LOAD;
                end
                LOAD: begin
                    if (c < 5'd16) mem_addr <= 16'(base + {blk[27:0], c[3:0]});
                    if (c != 5'd0 && c != 5'd17) blk_data[{~cw, 5'b0} +: 32] <= word;
                    c <= c + 5'd1;
                    if (c == 5'd17) begin
                        state <= OFFER;
                        blk_valid <= 1'b1;
                        blk_last <= final_blk;
                    end
                end
                OFFER: if (!blk_valid) begin
                    state <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end else if (blk_ready) begin
                    blk_valid <= 1'b0;
                    blk_last <= 1'b0;
                    if (!final_blk) begin
                        blk <= blk + 32'd1;
                        c <= '0;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
